// File: rtl/spi_ahb_pkg.sv
// spi_ahb_pkg: register offsets, SPI engine states and byte width shared by the SPI/AHB peripheral.
package spi_ahb_pkg;
    localparam logic [1:0] ADDR_TX = 2'b00;
    localparam logic [1:0] ADDR_RX = 2'b01;
    localparam int BYTE_W = 8;
    typedef enum logic {IDLE, SHIFT} spi_state_t;
endpackage

// File: rtl/spi_ahb_peripheral_if.sv
// spi_ahb_peripheral_if: AHB-Lite subset seen by the SPI peripheral.
interface spi_ahb_peripheral_if;
    logic        hsel;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    modport master (output hsel, hwrite, haddr, hwdata, input hrdata);
    modport slave (input hsel, hwrite, haddr, hwdata, output hrdata);
endinterface

// File: rtl/spi_core.sv
// spi_core: mode-0 MSB-first SPI byte shifter with programmable SCLK half-period.
module spi_core
    import spi_ahb_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] tx,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic              ss,
    output logic              busy,
    output logic [BYTE_W-1:0] rx
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * BYTE_W);
    spi_state_t state;
    logic [DW-1:0] div;
    logic [EW-1:0] edges;
    logic [BYTE_W-1:0] sh;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            div   <= '0;
            edges <= '0;
            sh    <= '0;
            rx    <= '0;
            mosi  <= 1'b0;
            sclk  <= 1'b0;
            ss    <= 1'b1;
            busy  <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                state <= SHIFT;
                sh    <= tx;
                mosi  <= tx[BYTE_W-1];
                div   <= '0;
                edges <= '0;
                ss    <= 1'b0;
                busy  <= 1'b1;
            end
        end else if (div == DW'(CLK_DIV - 1)) begin
            div   <= '0;
            edges <= edges + 1'b1;
            sclk  <= ~sclk;
            // Rising edge samples miso into the LSB; the next outgoing bit surfaces at sh[MSB].
            if (!sclk) sh <= {sh[BYTE_W-2:0], miso};
            else if (edges == EW'(2 * BYTE_W - 1)) begin
                state <= IDLE;
                rx    <= sh;
                mosi  <= 1'b0;
                sclk  <= 1'b0;
                ss    <= 1'b1;
                busy  <= 1'b0;
            end else mosi <= sh[BYTE_W-1];
        end else div <= div + 1'b1;
    end
endmodule

// File: rtl/spi_ahb_peripheral.sv
// spi_ahb_peripheral: AHB-Lite register front end (TX/STATUS, RX) around an SPI byte engine.
module spi_ahb_peripheral
    import spi_ahb_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_ahb_peripheral_if.slave   bus,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  sclk,
    output logic                  ss
);
    logic              pend, pend_wr, start, busy;
    logic [1:0]        pend_addr;
    logic [BYTE_W-1:0] tx, rx;
    logic              wr_ok;
    logic              unused;
    assign unused = ^{bus.haddr[31:4], bus.haddr[1:0], bus.hwdata[31:BYTE_W]};
    // Busy is the registered value at capture, so a write landing as busy drops still counts.
    assign wr_ok = pend && pend_wr && pend_addr == ADDR_TX && !busy;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend      <= 1'b0;
            pend_wr   <= 1'b0;
            pend_addr <= '0;
            start     <= 1'b0;
            tx        <= '0;
        end else begin
            pend      <= bus.hsel;
            pend_wr   <= bus.hwrite;
            pend_addr <= bus.haddr[3:2];
            start     <= wr_ok;
            if (wr_ok) tx <= bus.hwdata[BYTE_W-1:0];
        end
    end
    always_comb begin
        bus.hrdata = '0;
        if (pend && !pend_wr)
            bus.hrdata = pend_addr == ADDR_TX ? {31'b0, busy} :
                         pend_addr == ADDR_RX ? {{(32 - BYTE_W){1'b0}}, rx} : 32'b0;
    end
    spi_core #(.CLK_DIV(CLK_DIV)) u_core (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .tx   (tx),
        .miso (miso),
        .mosi (mosi),
        .sclk (sclk),
        .ss   (ss),
        .busy (busy),
        .rx   (rx)
    );
endmodule

// File: tb/tb_spi_ahb_peripheral.sv
// tb_spi_ahb_peripheral: scoreboard bench driving AHB reads/writes and a modelled SPI slave.
module tb_spi_ahb_peripheral;
    localparam int CLK_DIV = 2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic miso, mosi, sclk, ss;
    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rx[$];
    logic [7:0] miso_byte = 8'h00;
    int miso_idx = 0;
    int busy_cyc = 0;
    logic sclk_q = 1'b0;
    logic [31:0] d;

    spi_ahb_peripheral_if bus ();
    spi_ahb_peripheral #(.CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .miso(miso),
        .mosi(mosi),
        .sclk(sclk),
        .ss  (ss)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // SPI slave model: checks mosi on SCLK rise, shifts miso out on SCLK fall.
    always @(negedge clk) begin
        if (!ss) busy_cyc++;
        if (sclk && !sclk_q) begin
            if (exp_mosi.size() == 0) check("mosi_extra", 1, 0);
            else check("mosi", {31'b0, mosi}, {24'b0, exp_mosi.pop_front()});
        end
        if (!sclk && sclk_q && miso_idx < 7) miso_idx++;
        miso = miso_byte[3'(7 - miso_idx)];
        sclk_q = sclk;
    end

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] rd);
        bus.hsel = 1'b1; bus.hwrite = 1'b0; bus.haddr = a;
        @(negedge clk);
        bus.hsel = 1'b0;
        rd = bus.hrdata;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] wd);
        bus.hsel = 1'b1; bus.hwrite = 1'b1; bus.haddr = a;
        @(negedge clk);
        bus.hsel = 1'b0; bus.hwdata = wd;
        @(negedge clk);
    endtask

    task automatic wait_ss(input logic v);
        int n = 0;
        while (ss !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(v ? "ss_rise_wait" : "ss_fall_wait", {31'b0, ss}, {31'b0, v});
    endtask

    task automatic start_xfer(input logic [7:0] tx, input logic [7:0] rxb);
        for (int i = 7; i >= 0; i--) exp_mosi.push_back({7'b0, tx[i]});
        exp_rx.push_back(rxb);
        miso_byte = rxb;
        miso_idx = 0;
        busy_cyc = 0;
        ahb_write(32'h0, {24'h0, tx});
        wait_ss(1'b0);
    endtask

    task automatic end_xfer();
        wait_ss(1'b1);
        check("busy_len", busy_cyc, 16 * CLK_DIV);
        check("mosi_left", exp_mosi.size(), 0);
        ahb_read(32'h4, d);
        check("rxdata", d, {24'h0, exp_rx.pop_front()});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.hsel = 1'b0; bus.hwrite = 1'b0; bus.haddr = '0; bus.hwdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mosi", {31'b0, mosi}, 0);
        check("rst_sclk", {31'b0, sclk}, 0);
        check("rst_ss", {31'b0, ss}, 1);
        check("rst_hrdata", bus.hrdata, 0);
        rst = 1'b1;
        @(negedge clk);
        ahb_read(32'h0, d); check("rst_status", d, 0);
        ahb_read(32'h4, d); check("rst_rx", d, 0);
        ahb_read(32'h8, d); check("rd_08", d, 0);

        start_xfer(8'h13, 8'h37);
        ahb_read(32'h0, d); check("status_busy", d, 1);
        end_xfer();
        ahb_read(32'h0, d); check("status_idle", d, 0);

        start_xfer(8'h14, 8'h88);
        ahb_read(32'h4, d); check("rx_hold", d, 32'h37);
        end_xfer();

        ahb_write(32'h4, 32'hAA);
        ahb_read(32'h4, d); check("rx_ro", d, 32'h88);

        start_xfer(8'h5A, 8'hC3);
        repeat (5) @(negedge clk);
        ahb_write(32'h0, 32'hFF);
        end_xfer();
        busy_cyc = 0;
        repeat (40) @(negedge clk);
        check("no_restart", busy_cyc, 0);

        start_xfer(8'hFF, 8'hFF);
        repeat (6 * CLK_DIV) @(negedge clk);
        check("mid_ss_low", {31'b0, ss}, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_mosi", {31'b0, mosi}, 0);
        check("mid_rst_sclk", {31'b0, sclk}, 0);
        check("mid_rst_ss", {31'b0, ss}, 1);
        check("mid_rst_hrdata", bus.hrdata, 0);
        exp_mosi.delete();
        exp_rx.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ahb_read(32'h4, d); check("mid_rst_rx", d, 0);
        ahb_read(32'h0, d); check("mid_rst_status", d, 0);
        start_xfer(8'h13, 8'h37);
        end_xfer();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
